spatz_vsldu_wbuf: RTL and testbench



---
 rtl/spatz_vsldu_wbuf.sv | 186 ++++++++++++++++++
 tb/tb_spatz_vsldu_wbuf.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_vsldu_wbuf.sv
// spatz_vsldu_wbuf
// Write-back buffer between the vector slide unit and a VRF write port.
// Holds slide-unit write requests in a small circular FIFO so the unit keeps
// running while the write port back-pressures. A request that hits the same
// word and instruction as the youngest queued entry is merged into that entry
// instead of taking a new slot. Instruction-done pulses wait in a 2-deep queue
// and are only released as responses once no queued write of that instruction
// remains.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   in_valid_i / in_ready_o        write request handshake
//   in_waddr_i, in_wdata_i,
//   in_wbe_i, in_id_i              write request payload
//   vrf_we_o, vrf_waddr_o,
//   vrf_wdata_o, vrf_wbe_o,
//   vrf_id_o                       head entry presented to the VRF
//   vrf_wvalid_i                   VRF consumed the head entry this cycle
//   done_valid_i, done_id_i /
//   done_ready_o                   instruction-finished handshake
//   rsp_valid_o, rsp_id_o          instruction fully written back (1-cycle pulse)
//   empty_o                        FIFO holds no entries
module spatz_vsldu_wbuf #(
  parameter int unsigned NrEntries = 4,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AddrWidth-1:0]   in_waddr_i,
  input  logic [DataWidth-1:0]   in_wdata_i,
  input  logic [DataWidth/8-1:0] in_wbe_i,
  input  logic [IdWidth-1:0]     in_id_i,
  output logic                   vrf_we_o,
  output logic [AddrWidth-1:0]   vrf_waddr_o,
  output logic [DataWidth-1:0]   vrf_wdata_o,
  output logic [DataWidth/8-1:0] vrf_wbe_o,
  output logic [IdWidth-1:0]     vrf_id_o,
  input  logic                   vrf_wvalid_i,
  input  logic                   done_valid_i,
  input  logic [IdWidth-1:0]     done_id_i,
  output logic                   done_ready_o,
  output logic                   rsp_valid_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic                   empty_o
);

  localparam int unsigned PtrWidth = $clog2(NrEntries);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam int unsigned BeWidth  = DataWidth / 8;

  // Byte-wise overwrite of old data with new data where the enable is set.
  function automatic logic [DataWidth-1:0] merge_bytes(
    input logic [DataWidth-1:0] old_data,
    input logic [DataWidth-1:0] new_data,
    input logic [BeWidth-1:0]   be
  );
    logic [DataWidth-1:0] res;
    res = old_data;
    for (int unsigned b = 0; b < BeWidth; b++) begin
      if (be[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
      else       res[b*8 +: 8] = old_data[b*8 +: 8];
    end
    return res;
  endfunction

  // An entry slot is live when its distance from head is below count.
  function automatic logic entry_live(
    input logic [PtrWidth-1:0] idx,
    input logic [PtrWidth-1:0] head,
    input logic [CntWidth-1:0] count
  );
    logic [PtrWidth-1:0] rel;
    rel = idx - head;
    return ({1'b0, rel} < count);
  endfunction

  // Entry storage (intentionally not reset; liveness comes from head/count)
  logic [AddrWidth-1:0] addr_q [NrEntries];
  logic [DataWidth-1:0] data_q [NrEntries];
  logic [BeWidth-1:0]   wbe_q  [NrEntries];
  logic [IdWidth-1:0]   id_q   [NrEntries];

  logic [PtrWidth-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic [IdWidth-1:0]  done_id_q [2];
  logic                done_head_q, done_head_d;
  logic [1:0]          done_cnt_q, done_cnt_d;

  logic                push_s, merge_s, push_new_s, pop_s;
  logic [PtrWidth-1:0] youngest_s;
  logic                done_push_s, retire_s, match_s;
  logic                done_wr_idx_s;
  logic [IdWidth-1:0]  done_head_id_s;

  assign in_ready_o = (count_q < CntWidth'(NrEntries));
  assign empty_o    = (count_q == '0);
  assign push_s     = in_valid_i & in_ready_o;
  assign pop_s      = vrf_we_o & vrf_wvalid_i;
  assign youngest_s = tail_q - PtrWidth'(1);
  // With count >= 2 the youngest entry cannot be the head currently presented.
  assign merge_s    = push_s && (count_q >= CntWidth'(2)) &&
                      (addr_q[youngest_s] == in_waddr_i) &&
                      (id_q[youngest_s] == in_id_i);
  assign push_new_s = push_s & ~merge_s;

  assign vrf_we_o    = ~empty_o;
  assign vrf_waddr_o = addr_q[head_q];
  assign vrf_wdata_o = data_q[head_q];
  assign vrf_wbe_o   = wbe_q[head_q];
  assign vrf_id_o    = id_q[head_q];

  assign done_ready_o   = (done_cnt_q != 2'd2);
  assign done_push_s    = done_valid_i & done_ready_o;
  assign done_wr_idx_s  = done_head_q ^ done_cnt_q[0];
  assign done_head_id_s = done_id_q[done_head_q];

  // Search live FIFO entries for the id at the head of the done queue.
  always_comb begin
    match_s = 1'b0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      if (entry_live(PtrWidth'(i), head_q, count_q) && (id_q[i] == done_head_id_s)) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
  end

  assign retire_s    = (done_cnt_q != 2'd0) & ~match_s;
  assign rsp_valid_o = retire_s;
  assign rsp_id_o    = retire_s ? done_head_id_s : '0;

  // Next-state for FIFO pointers/count and done-queue pointers.
  always_comb begin
    head_d      = pop_s ? (head_q + PtrWidth'(1)) : head_q;
    tail_d      = push_new_s ? (tail_q + PtrWidth'(1)) : tail_q;
    count_d     = count_q + CntWidth'(push_new_s) - CntWidth'(pop_s);
    done_head_d = retire_s ? ~done_head_q : done_head_q;
    done_cnt_d  = done_cnt_q + 2'(done_push_s) - 2'(retire_s);
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      done_head_q <= 1'b0;
      done_cnt_q  <= 2'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      done_head_q <= done_head_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Entry storage: new entries land at tail, merges update the youngest entry.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      if (merge_s) begin
        data_q[youngest_s] <= merge_bytes(data_q[youngest_s], in_wdata_i, in_wbe_i);
        wbe_q[youngest_s]  <= wbe_q[youngest_s] | in_wbe_i;
      end else begin
        addr_q[tail_q] <= in_waddr_i;
        data_q[tail_q] <= in_wdata_i;
        wbe_q[tail_q]  <= in_wbe_i;
        id_q[tail_q]   <= in_id_i;
      end
    end
  end

  // Done-queue id storage.
  always_ff @(posedge clk_i) begin
    if (done_push_s) begin
      done_id_q[done_wr_idx_s] <= done_id_i;
    end
  end

endmodule

// File: tb/tb_spatz_vsldu_wbuf.sv
module tb_spatz_vsldu_wbuf;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_waddr_i;
  logic [63:0] in_wdata_i;
  logic [7:0]  in_wbe_i;
  logic [2:0]  in_id_i;
  logic        vrf_we_o;
  logic [7:0]  vrf_waddr_o;
  logic [63:0] vrf_wdata_o;
  logic [7:0]  vrf_wbe_o;
  logic [2:0]  vrf_id_o;
  logic        vrf_wvalid_i;
  logic        done_valid_i;
  logic [2:0]  done_id_i;
  logic        done_ready_o;
  logic        rsp_valid_o;
  logic [2:0]  rsp_id_o;
  logic        empty_o;

  int checks   = 0;
  int failures = 0;
  int rsp_total = 0;
  int rsp_id4   = 0;
  logic [7:0] exp_q[$];

  spatz_vsldu_wbuf #(.NrEntries(4), .AddrWidth(8), .DataWidth(64), .IdWidth(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_waddr_i(in_waddr_i), .in_wdata_i(in_wdata_i), .in_wbe_i(in_wbe_i), .in_id_i(in_id_i),
    .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
    .vrf_wbe_o(vrf_wbe_o), .vrf_id_o(vrf_id_o), .vrf_wvalid_i(vrf_wvalid_i),
    .done_valid_i(done_valid_i), .done_id_i(done_id_i), .done_ready_o(done_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // Response monitor and illegal-done guard.
  always @(negedge clk) begin
    if (rsp_valid_o) begin
      rsp_total++;
      if (rsp_id_o == 3'd4) rsp_id4++;
    end
    if (!rst_i && done_valid_i && !done_ready_o) begin
      failures++;
      $error("FAIL illegal_done: done_valid_i while done_ready_o=0");
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be, input logic [2:0] id);
    in_valid_i = 1'b1; in_waddr_i = a; in_wdata_i = d; in_wbe_i = be; in_id_i = id;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},        64'(vrf_we_o),     64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o),  64'd0);
    check({tag, "_rsp_id"},    64'(rsp_id_o),     64'd0);
    check({tag, "_done_rdy"},  64'(done_ready_o), 64'd1);
    check({tag, "_in_rdy"},    64'(in_ready_o),   64'd1);
    check({tag, "_empty"},     64'(empty_o),      64'd1);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_waddr_i = 8'd0; in_wdata_i = 64'd0;
    in_wbe_i = 8'd0; in_id_i = 3'd0; vrf_wvalid_i = 1'b0;
    done_valid_i = 1'b0; done_id_i = 3'd0;
    step(); step();
    check_reset_outputs("reset");
    rst_i = 1'b0;

    // Single write: visible the cycle after acceptance, gone the cycle after pop.
    vrf_wvalid_i = 1'b1;
    push(8'h10, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 3'd2);
    check("single_we",   64'(vrf_we_o),    64'd1);
    check("single_addr", 64'(vrf_waddr_o), 64'h10);
    check("single_data", vrf_wdata_o,      64'hDEAD_BEEF_0BAD_F00D);
    step();
    check("single_empty", 64'(empty_o),  64'd1);
    check("single_we0",   64'(vrf_we_o), 64'd0);

    // Coalescing: C merges into B (same addr/id, count==2).
    vrf_wvalid_i = 1'b0;
    push(8'h05, 64'h0000_0000_1122_3344, 8'h0F, 3'd1);
    push(8'h06, 64'h0000_0000_0506_0708, 8'h0F, 3'd1);
    push(8'h06, 64'hA1A2_A3A4_0000_0000, 8'hF0, 3'd1);
    check("coal_in_rdy", 64'(in_ready_o),  64'd1);
    check("coal_head",   64'(vrf_waddr_o), 64'h05);
    vrf_wvalid_i = 1'b1;
    check("coal_w1_data", vrf_wdata_o,     64'h0000_0000_1122_3344);
    check("coal_w1_wbe",  64'(vrf_wbe_o),  64'h0F);
    step();
    check("coal_w2_addr", 64'(vrf_waddr_o), 64'h06);
    check("coal_w2_wbe",  64'(vrf_wbe_o),   64'hFF);
    check("coal_w2_data", vrf_wdata_o,      64'hA1A2_A3A4_0506_0708);
    step();
    check("coal_empty", 64'(empty_o), 64'd1);

    // No merge at count==1; no merge across ids.
    vrf_wvalid_i = 1'b0;
    push(8'h09, 64'h1111_1111_1111_1111, 8'h0F, 3'd1);
    push(8'h09, 64'h2222_2222_2222_2222, 8'hF0, 3'd1);
    push(8'h09, 64'h3333_3333_3333_3333, 8'h01, 3'd2);
    vrf_wvalid_i = 1'b1;
    check("nomerge_w1_wbe", 64'(vrf_wbe_o), 64'h0F);
    step();
    check("nomerge_w2_wbe", 64'(vrf_wbe_o), 64'hF0);
    step();
    check("nomerge_w3_wbe", 64'(vrf_wbe_o), 64'h01);
    check("nomerge_w3_id",  64'(vrf_id_o),  64'd2);
    step();
    check("nomerge_empty", 64'(empty_o), 64'd1);

    // Full and wrap.
    vrf_wvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'h20 + 8'(i), 64'(i), 8'hFF, 3'd1);
      exp_q.push_back(8'h20 + 8'(i));
    end
    check("full_in_rdy0", 64'(in_ready_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      vrf_wvalid_i = 1'b1;
      check("wrap_full_rdy0", 64'(in_ready_o),  64'd0);
      check("wrap_pop_addr",  64'(vrf_waddr_o), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      step();
      vrf_wvalid_i = 1'b0;
      check("wrap_rdy1", 64'(in_ready_o), 64'd1);
      push(8'h30 + 8'(i), 64'(i), 8'hFF, 3'd1);
      exp_q.push_back(8'h30 + 8'(i));
    end
    vrf_wvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", 64'(vrf_waddr_o), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      step();
    end
    check("drain_empty", 64'(empty_o), 64'd1);

    // Deferred response.
    vrf_wvalid_i = 1'b0;
    push(8'h40, 64'd0, 8'hFF, 3'd1);
    push(8'h41, 64'd0, 8'hFF, 3'd1);
    push(8'h42, 64'd0, 8'hFF, 3'd1);
    done_valid_i = 1'b1; done_id_i = 3'd1;
    step();
    done_valid_i = 1'b0;
    check("defer_no_rsp0", 64'(rsp_valid_o), 64'd0);
    vrf_wvalid_i = 1'b1;
    step(); step();
    check("defer_no_rsp2", 64'(rsp_valid_o), 64'd0);
    step();
    vrf_wvalid_i = 1'b0;
    check("defer_rsp",    64'(rsp_valid_o), 64'd1);
    check("defer_rsp_id", 64'(rsp_id_o),    64'd1);
    step();
    check("defer_pulse", 64'(rsp_valid_o), 64'd0);

    // Done queue back-to-back, no pending entries.
    done_valid_i = 1'b1; done_id_i = 3'd1;
    step();
    done_id_i = 3'd3;
    check("dq_rsp1",    64'(rsp_valid_o),  64'd1);
    check("dq_rsp1_id", 64'(rsp_id_o),     64'd1);
    check("dq_rdy",     64'(done_ready_o), 64'd1);
    step();
    done_valid_i = 1'b0;
    check("dq_rsp3",    64'(rsp_valid_o), 64'd1);
    check("dq_rsp3_id", 64'(rsp_id_o),    64'd3);
    step();
    check("dq_idle", 64'(rsp_valid_o), 64'd0);

    // Done queue fills: id 5 blocked by an entry, id 6 waits behind it in order.
    push(8'h50, 64'd0, 8'hFF, 3'd5);
    done_valid_i = 1'b1; done_id_i = 3'd5;
    step();
    done_id_i = 3'd6;
    check("dqf_rdy_one", 64'(done_ready_o), 64'd1);
    check("dqf_no_rsp",  64'(rsp_valid_o),  64'd0);
    step();
    done_valid_i = 1'b0;
    check("dqf_rdy_full",  64'(done_ready_o), 64'd0);
    check("dqf_no_rsp2",   64'(rsp_valid_o),  64'd0);
    vrf_wvalid_i = 1'b1;
    step();
    vrf_wvalid_i = 1'b0;
    check("dqf_rsp5",      64'(rsp_id_o),     64'd5);
    check("dqf_rsp5_v",    64'(rsp_valid_o),  64'd1);
    check("dqf_rdy_full2", 64'(done_ready_o), 64'd0);
    step();
    check("dqf_rsp6",   64'(rsp_id_o),     64'd6);
    check("dqf_rsp6_v", 64'(rsp_valid_o),  64'd1);
    check("dqf_rdy",    64'(done_ready_o), 64'd1);
    step();
    check("dqf_idle", 64'(rsp_valid_o), 64'd0);

    // Reset mid-operation discards entries and the pending done.
    push(8'h60, 64'd0, 8'hFF, 3'd4);
    push(8'h61, 64'd0, 8'hFF, 3'd4);
    push(8'h62, 64'd0, 8'hFF, 3'd4);
    done_valid_i = 1'b1; done_id_i = 3'd4;
    step();
    done_valid_i = 1'b0;
    check("mid_no_rsp", 64'(rsp_valid_o), 64'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_reset_outputs("midrst");
    vrf_wvalid_i = 1'b1;
    repeat (6) step();
    check("rsp_id4_never", 64'(rsp_id4),   64'd0);
    check("rsp_total",     64'(rsp_total), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
